// File: rtl/nes_video_pkg.sv
// Shared frame geometry, writer FSM states and the NES palette (RGB444) for the
// frame buffer write path.
package nes_video_pkg;

  localparam int FB_W = 256;
  localparam int FB_H = 240;

  typedef enum logic [1:0] {IDLE, ACTIVE, DONE} fb_state_t;

  // 2C02 palette reduced to the top nibble of each 8-bit channel.
  localparam logic [11:0] NES_PALETTE [64] = '{
    12'h777, 12'h00F, 12'h00B, 12'h42B, 12'h908, 12'hA02, 12'hA10, 12'h810,
    12'h530, 12'h070, 12'h060, 12'h050, 12'h045, 12'h000, 12'h000, 12'h000,
    12'hBBB, 12'h07F, 12'h05F, 12'h64F, 12'hD0C, 12'hE05, 12'hF30, 12'hE51,
    12'hA70, 12'h0B0, 12'h0A0, 12'h0A4, 12'h088, 12'h000, 12'h000, 12'h000,
    12'hFFF, 12'h3BF, 12'h68F, 12'h97F, 12'hF7F, 12'hF59, 12'hF75, 12'hFA4,
    12'hFB0, 12'hBF1, 12'h5D5, 12'h5F9, 12'h0ED, 12'h777, 12'h000, 12'h000,
    12'hFFF, 12'hAEF, 12'hBBF, 12'hDBF, 12'hFBF, 12'hFAC, 12'hFDB, 12'hFEA,
    12'hFD7, 12'hDF7, 12'hBFB, 12'hBFD, 12'h0FF, 12'hFDF, 12'h000, 12'h000
  };

endpackage

// File: rtl/nes_palette_rom.sv
// Registered palette lookup: 6-bit NES colour index to RGB444. Holds its output
// when no pixel is being converted.
module nes_palette_rom
  import nes_video_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [5:0]  idx,
  output logic [11:0] rgb
);

  logic [11:0] rgb_d, rgb_q;

  always_comb begin
    rgb_d = rgb_q;
    if (en) rgb_d = NES_PALETTE[idx];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rgb_q <= '0;
    else      rgb_q <= rgb_d;
  end

  assign rgb = rgb_q;

endmodule

// File: rtl/frame_buffer_writer.sv
// Write side of the double-buffered NES frame buffer: accepts the PPU pixel
// stream, converts to RGB444 and writes y*256+x into the bank not on display.
module frame_buffer_writer
  import nes_video_pkg::*;
#(
  parameter int ADDR_W = 20,
  parameter int FB_W   = nes_video_pkg::FB_W,
  parameter int FB_H   = nes_video_pkg::FB_H
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_start,
  input  logic              pix_valid,
  input  logic [5:0]        pix_color,
  output logic              pix_ready,
  output logic              fb_we,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [11:0]       fb_data,
  output logic              fb_bank,
  output logic              frame_done,
  output logic              frame_overrun
);

  fb_state_t         state_d, state_q;
  logic [7:0]        x_d, x_q, y_d, y_q;
  logic              s1_vld_d, s1_vld_q, s1_last_d, s1_last_q;
  logic [5:0]        s1_color_d, s1_color_q;
  logic [15:0]       s1_yx_d, s1_yx_q;
  logic              fb_we_d, fb_we_q, frame_done_d, frame_done_q;
  logic              fb_bank_d, fb_bank_q, frame_overrun_d, frame_overrun_q;
  logic [ADDR_W-1:0] fb_addr_d, fb_addr_q;
  logic              accept, last_pix, eol;

  assign pix_ready = (state_q == ACTIVE) & ~frame_start;
  assign accept    = pix_valid & pix_ready;
  assign eol       = (x_q == 8'(FB_W - 1));
  assign last_pix  = eol && (y_q == 8'(FB_H - 1));

  always_comb begin
    state_d         = state_q;
    x_d             = x_q;
    y_d             = y_q;
    frame_overrun_d = 1'b0;
    s1_vld_d        = accept;
    s1_color_d      = s1_color_q;
    s1_yx_d         = s1_yx_q;
    s1_last_d       = s1_last_q;
    if (frame_start) begin
      frame_overrun_d = (state_q == ACTIVE);
      state_d         = ACTIVE;
      x_d             = 8'd0;
      y_d             = 8'd0;
    end else if (accept) begin
      s1_color_d = pix_color;
      s1_yx_d    = {y_q, x_q};
      s1_last_d  = last_pix;
      if (eol) begin
        x_d = 8'd0;
        y_d = last_pix ? 8'd0 : y_q + 8'd1;
      end else begin
        x_d = x_q + 8'd1;
      end
      if (last_pix) state_d = DONE;
    end
    fb_we_d      = s1_vld_q;
    frame_done_d = s1_vld_q & s1_last_q;
    // Bank bit is taken at S2 so a frame restarted right after DONE already
    // sees the flipped display bank.
    fb_addr_d    = s1_vld_q ? ADDR_W'({~fb_bank_q, s1_yx_q}) : fb_addr_q;
    fb_bank_d    = fb_bank_q ^ frame_done_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= IDLE;
      x_q             <= '0;
      y_q             <= '0;
      s1_vld_q        <= 1'b0;
      s1_color_q      <= '0;
      s1_yx_q         <= '0;
      s1_last_q       <= 1'b0;
      fb_we_q         <= 1'b0;
      fb_addr_q       <= '0;
      frame_done_q    <= 1'b0;
      fb_bank_q       <= 1'b0;
      frame_overrun_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      x_q             <= x_d;
      y_q             <= y_d;
      s1_vld_q        <= s1_vld_d;
      s1_color_q      <= s1_color_d;
      s1_yx_q         <= s1_yx_d;
      s1_last_q       <= s1_last_d;
      fb_we_q         <= fb_we_d;
      fb_addr_q       <= fb_addr_d;
      frame_done_q    <= frame_done_d;
      fb_bank_q       <= fb_bank_d;
      frame_overrun_q <= frame_overrun_d;
    end
  end

  nes_palette_rom u_palette (
    .clk (clk),
    .rst (rst),
    .en  (s1_vld_q),
    .idx (s1_color_q),
    .rgb (fb_data)
  );

  assign fb_we         = fb_we_q;
  assign fb_addr       = fb_addr_q;
  assign frame_done    = frame_done_q;
  assign fb_bank       = fb_bank_q;
  assign frame_overrun = frame_overrun_q;

endmodule
